// File: rtl/core_v_mcu_pkg.sv
// rtl/core_v_mcu_pkg.sv - SoC-level address map constants shared across the MCU
package core_v_mcu_pkg;

    localparam int AxiAddrWidth = 32;

    localparam logic [31:0] SOC_CTRL_START_ADDR       = 32'h1A10_4000;
    localparam logic [31:0] SOC_CTRL_SIZE             = 32'h0000_1000;
    localparam logic [31:0] FAST_INTR_CTRL_START_ADDR = 32'h1A10_9800;
    localparam logic [31:0] FAST_INTR_CTRL_SIZE       = 32'h0000_0800;
    localparam logic [31:0] UART_START_ADDR           = 32'h1A10_2100;
    localparam logic [31:0] UART_SIZE                 = 32'h0000_0080;

endpackage

// File: rtl/ni_periph_arbiter_pkg.sv
// rtl/ni_periph_arbiter_pkg.sv - FSM state type and peripheral region decode for ni_periph_arbiter
package ni_periph_arbiter_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StResp,
        StDecErr,
        StAbort
    } arbState_e;

    localparam int NumRegions = 3;

    localparam logic [63:0] RegionBase [NumRegions] = '{
        64'(core_v_mcu_pkg::SOC_CTRL_START_ADDR),
        64'(core_v_mcu_pkg::FAST_INTR_CTRL_START_ADDR),
        64'(core_v_mcu_pkg::UART_START_ADDR)
    };

    localparam logic [63:0] RegionSize [NumRegions] = '{
        64'(core_v_mcu_pkg::SOC_CTRL_SIZE),
        64'(core_v_mcu_pkg::FAST_INTR_CTRL_SIZE),
        64'(core_v_mcu_pkg::UART_SIZE)
    };

    function automatic logic addrHit(input logic [63:0] addr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NumRegions; i++) begin
            if (addr >= RegionBase[i] && addr < RegionBase[i] + RegionSize[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/ni_periph_arbiter_rr_select.sv
// rtl/ni_periph_arbiter_rr_select.sv - round-robin pick starting after the last owner
module rr_select #(
    parameter int NumReq = 2,
    parameter int IdxW   = 1
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   lastOwner,
    output logic [NumReq-1:0] gnt,
    output logic [IdxW-1:0]   idx
);

    int   cand;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NumReq; k++) begin
            cand = int'(lastOwner) + k;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!found && req[cand[IdxW-1:0]]) begin
                found                 = 1'b1;
                idx                   = cand[IdxW-1:0];
                gnt[cand[IdxW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ni_periph_arbiter.sv
// rtl/ni_periph_arbiter.sv - arbitrates OBI-style requesters onto one peripheral port with decode error and timeout
module ni_periph_arbiter
    import ni_periph_arbiter_pkg::*;
#(
    parameter int NumReq        = 2,
    parameter int AddrWidth     = core_v_mcu_pkg::AxiAddrWidth,
    parameter int DataWidth     = 64,
    parameter int TimeoutCycles = 255
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumReq-1:0]                   req_i,
    input  logic [NumReq-1:0]                   we_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]  be_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
    output logic [NumReq-1:0]                   gnt_o,
    output logic [NumReq-1:0]                   rvalid_o,
    output logic [NumReq-1:0]                   err_o,
    output logic [DataWidth-1:0]                rdata_o,
    output logic                                periph_req_o,
    output logic                                periph_we_o,
    output logic [AddrWidth-1:0]                periph_addr_o,
    output logic [DataWidth/8-1:0]              periph_be_o,
    output logic [DataWidth-1:0]                periph_wdata_o,
    input  logic                                periph_gnt_i,
    input  logic                                periph_rvalid_i,
    input  logic                                periph_err_i,
    input  logic [DataWidth-1:0]                periph_rdata_i,
    output logic                                timeout_o,
    input  logic                                clr_timeout_i,
    output logic                                busy_o
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CntW = 16;
    localparam logic [CntW-1:0] TmoLimit = CntW'(TimeoutCycles);

    arbState_e              state;
    logic [IdxW-1:0]        lastOwner;
    logic [NumReq-1:0]      ownerOh;
    logic [CntW-1:0]        cnt;
    logic                   timeoutQ;
    logic                   weQ;
    logic [AddrWidth-1:0]   addrQ;
    logic [DataWidth/8-1:0] beQ;
    logic [DataWidth-1:0]   wdataQ;
    logic [NumReq-1:0]      selOh;
    logic [IdxW-1:0]        selIdx;

    rr_select #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr_select (
        .req       (req_i),
        .lastOwner (lastOwner),
        .gnt       (selOh),
        .idx       (selIdx)
    );

    // cnt counts RESP/ABORT cycles; in DECERR it only separates the grant cycle from the response cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= StIdle;
            lastOwner <= IdxW'(NumReq - 1);
            ownerOh   <= '0;
            cnt       <= '0;
            timeoutQ  <= 1'b0;
            weQ       <= 1'b0;
            addrQ     <= '0;
            beQ       <= '0;
            wdataQ    <= '0;
        end else begin
            if (clr_timeout_i) begin
                timeoutQ <= 1'b0;
            end
            unique case (state)
                StIdle: begin
                    cnt <= '0;
                    if (|req_i) begin
                        lastOwner <= selIdx;
                        ownerOh   <= selOh;
                        weQ       <= we_i[selIdx];
                        addrQ     <= addr_i[selIdx];
                        beQ       <= be_i[selIdx];
                        wdataQ    <= wdata_i[selIdx];
                        state     <= addrHit(64'(addr_i[selIdx])) ? StReq : StDecErr;
                    end
                end
                StReq: begin
                    if (periph_gnt_i) begin
                        cnt   <= '0;
                        state <= StResp;
                    end
                end
                StResp: begin
                    if (periph_rvalid_i) begin
                        state <= StIdle;
                    end else if (cnt == TmoLimit) begin
                        timeoutQ <= 1'b1;
                        cnt      <= '0;
                        state    <= StAbort;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                StDecErr: begin
                    if (cnt == '0) begin
                        cnt <= CntW'(1);
                    end else begin
                        cnt   <= '0;
                        state <= StIdle;
                    end
                end
                StAbort: begin
                    // a peripheral that never answers must not wedge the port, so ABORT is bounded too
                    if (periph_rvalid_i || cnt == TmoLimit) begin
                        cnt   <= '0;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        gnt_o          = '0;
        rvalid_o       = '0;
        err_o          = '0;
        rdata_o        = '0;
        periph_req_o   = 1'b0;
        periph_we_o    = 1'b0;
        periph_addr_o  = '0;
        periph_be_o    = '0;
        periph_wdata_o = '0;
        busy_o         = 1'b0;
        timeout_o      = 1'b0;
        if (!rst_i) begin
            busy_o    = (state != StIdle);
            timeout_o = timeoutQ;
            unique case (state)
                StReq: begin
                    periph_req_o   = 1'b1;
                    periph_we_o    = weQ;
                    periph_addr_o  = addrQ;
                    periph_be_o    = beQ;
                    periph_wdata_o = wdataQ;
                    gnt_o          = ownerOh & {NumReq{periph_gnt_i}};
                end
                StResp: begin
                    if (periph_rvalid_i) begin
                        rvalid_o = ownerOh;
                        err_o    = ownerOh & {NumReq{periph_err_i}};
                        rdata_o  = periph_rdata_i;
                    end else if (cnt == TmoLimit) begin
                        rvalid_o = ownerOh;
                        err_o    = ownerOh;
                    end
                end
                StDecErr: begin
                    if (cnt == '0) begin
                        gnt_o = ownerOh;
                    end else begin
                        rvalid_o = ownerOh;
                        err_o    = ownerOh;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ni_periph_arbiter.sv
// tb/tb_ni_periph_arbiter.sv - directed-scenario bench for ni_periph_arbiter with a latency-timeline model
module tb_ni_periph_arbiter;

    localparam int NumCyc = 62;
    localparam int Tmo    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, clrTmo;
    logic [1:0]       req, we;
    logic [1:0][31:0] addr;
    logic [1:0][7:0]  be;
    logic [1:0][63:0] wdata;
    logic [1:0]       gnt, rvalid, err;
    logic [63:0]      rdata;
    logic             pReq, pWe, pGnt, pRv, pErr;
    logic [31:0]      pAddr;
    logic [7:0]       pBe;
    logic [63:0]      pWdata, pRdata;
    logic             tmo, busy;

    ni_periph_arbiter #(
        .NumReq        (2),
        .AddrWidth     (32),
        .DataWidth     (64),
        .TimeoutCycles (Tmo)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_i           (req),
        .we_i            (we),
        .addr_i          (addr),
        .be_i            (be),
        .wdata_i         (wdata),
        .gnt_o           (gnt),
        .rvalid_o        (rvalid),
        .err_o           (err),
        .rdata_o         (rdata),
        .periph_req_o    (pReq),
        .periph_we_o     (pWe),
        .periph_addr_o   (pAddr),
        .periph_be_o     (pBe),
        .periph_wdata_o  (pWdata),
        .periph_gnt_i    (pGnt),
        .periph_rvalid_i (pRv),
        .periph_err_i    (pErr),
        .periph_rdata_i  (pRdata),
        .timeout_o       (tmo),
        .clr_timeout_i   (clrTmo),
        .busy_o          (busy)
    );

    // stimulus per cycle
    logic [1:0]       stReq   [NumCyc];
    logic [1:0]       stWe    [NumCyc];
    logic [1:0][31:0] stAddr  [NumCyc];
    logic [1:0][7:0]  stBe    [NumCyc];
    logic [1:0][63:0] stWdata [NumCyc];
    logic             stRst   [NumCyc];
    logic             stClr   [NumCyc];
    logic             stPGnt  [NumCyc];
    logic             stPRv   [NumCyc];
    logic             stPErr  [NumCyc];
    logic [63:0]      stPRdata[NumCyc];

    // expected outputs per cycle
    logic [1:0]  expGnt   [NumCyc];
    logic [1:0]  expRv    [NumCyc];
    logic [1:0]  expErr   [NumCyc];
    logic [63:0] expRdata [NumCyc];
    logic        expPReq  [NumCyc];
    logic        expPWe   [NumCyc];
    logic [31:0] expPAddr [NumCyc];
    logic [7:0]  expPBe   [NumCyc];
    logic [63:0] expPWdata[NumCyc];
    logic        expBusy  [NumCyc];
    logic        expTmo   [NumCyc];

    int nChecks = 0;
    int nFails  = 0;

    task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    task automatic hold(input int c, input int r, input logic [31:0] a, input logic w,
                        input logic [7:0] b, input logic [63:0] d);
        stReq[c][r] = 1'b1; stAddr[c][r] = a; stWe[c][r] = w; stBe[c][r] = b; stWdata[c][r] = d;
    endtask

    task automatic expIssue(input int c, input logic [31:0] a, input logic w,
                            input logic [7:0] b, input logic [63:0] d);
        expPReq[c] = 1'b1; expPAddr[c] = a; expPWe[c] = w; expPBe[c] = b; expPWdata[c] = d;
    endtask

    // mapped access: selected at s, issued from s+1, granted gntDly cycles later, answered rvDly after grant
    task automatic txnOk(input int reqStart, input int s, input int r, input logic [31:0] a, input logic w,
                         input logic [7:0] b, input logic [63:0] d, input int gntDly, input int rvDly,
                         input logic [63:0] rd, input logic pe);
        int g, v;
        g = s + 1 + gntDly;
        v = g + rvDly;
        for (int c = reqStart; c <= g; c++) hold(c, r, a, w, b, d);
        for (int c = s + 1; c <= g; c++) expIssue(c, a, w, b, d);
        stPGnt[g] = 1'b1;
        expGnt[g][r] = 1'b1;
        stPRv[v] = 1'b1; stPRdata[v] = rd; stPErr[v] = pe;
        expRv[v][r] = 1'b1; expErr[v][r] = pe; expRdata[v] = rd;
        for (int c = s + 1; c <= v; c++) expBusy[c] = 1'b1;
    endtask

    task automatic txnDec(input int s, input int r, input logic [31:0] a, input logic w,
                          input logic [7:0] b, input logic [63:0] d);
        for (int c = s; c <= s + 1; c++) hold(c, r, a, w, b, d);
        expGnt[s + 1][r] = 1'b1;
        expRv[s + 2][r] = 1'b1;
        expErr[s + 2][r] = 1'b1;
        expBusy[s + 1] = 1'b1;
        expBusy[s + 2] = 1'b1;
    endtask

    // no response: error after Tmo full RESP cycles, late response at 'late' swallowed, flag cleared at 'clr'
    task automatic txnTmo(input int s, input int r, input logic [31:0] a, input logic w,
                          input logic [7:0] b, input logic [63:0] d, input int gntDly,
                          input int late, input logic [63:0] lateData, input int clr);
        int g, fire;
        g = s + 1 + gntDly;
        fire = g + 1 + Tmo;
        for (int c = s; c <= g; c++) hold(c, r, a, w, b, d);
        for (int c = s + 1; c <= g; c++) expIssue(c, a, w, b, d);
        stPGnt[g] = 1'b1;
        expGnt[g][r] = 1'b1;
        expRv[fire][r] = 1'b1;
        expErr[fire][r] = 1'b1;
        for (int c = fire + 1; c <= clr; c++) expTmo[c] = 1'b1;
        stPRv[late] = 1'b1; stPRdata[late] = lateData;
        for (int c = s + 1; c <= late; c++) expBusy[c] = 1'b1;
        stClr[clr] = 1'b1;
    endtask

    task automatic txnRst(input int s, input int r, input logic [31:0] a, input logic w,
                          input logic [7:0] b, input logic [63:0] d, input int gntDly, input int rstCyc);
        int g;
        g = s + 1 + gntDly;
        for (int c = s; c <= g; c++) hold(c, r, a, w, b, d);
        for (int c = s + 1; c <= g; c++) expIssue(c, a, w, b, d);
        stPGnt[g] = 1'b1;
        expGnt[g][r] = 1'b1;
        for (int c = s + 1; c < rstCyc; c++) expBusy[c] = 1'b1;
        stRst[rstCyc] = 1'b1;
    endtask

    task automatic drive(input int c);
        rst = stRst[c]; clrTmo = stClr[c];
        req = stReq[c]; we = stWe[c]; addr = stAddr[c]; be = stBe[c]; wdata = stWdata[c];
        pGnt = stPGnt[c]; pRv = stPRv[c]; pErr = stPErr[c]; pRdata = stPRdata[c];
    endtask

    initial begin
        for (int c = 0; c < NumCyc; c++) begin
            stReq[c] = '0; stWe[c] = '0; stAddr[c] = '0; stBe[c] = '0; stWdata[c] = '0;
            stRst[c] = 1'b0; stClr[c] = 1'b0; stPGnt[c] = 1'b0; stPRv[c] = 1'b0;
            stPErr[c] = 1'b0; stPRdata[c] = '0;
            expGnt[c] = '0; expRv[c] = '0; expErr[c] = '0; expRdata[c] = '0;
            expPReq[c] = 1'b0; expPWe[c] = 1'b0; expPAddr[c] = '0; expPBe[c] = '0;
            expPWdata[c] = '0; expBusy[c] = 1'b0; expTmo[c] = 1'b0;
        end
        for (int c = 0; c <= 2; c++) stRst[c] = 1'b1;

        // both requesters to UART: 0 first, then 1
        txnOk(4, 4, 0, 32'h1A10_2108, 1'b0, 8'hFF, 64'h0, 0, 1, 64'h1111, 1'b0);
        txnOk(4, 7, 1, 32'h1A10_2108, 1'b0, 8'hFF, 64'h0, 0, 1, 64'h2222, 1'b0);
        // SOC_CTRL read, slow grant; requester scribbles its payload after latching
        txnOk(11, 11, 0, 32'h1A10_4000, 1'b0, 8'hFF, 64'h0, 3, 2, 64'hDEAD_BEEF, 1'b0);
        for (int c = 13; c <= 15; c++) begin
            stAddr[c][0] = 32'h0; stWe[c][0] = 1'b1;
        end
        // unmapped write, stray responses during DECERR
        txnDec(19, 1, 32'h0, 1'b1, 8'hF0, 64'hAAAA_5555);
        stPRv[20] = 1'b1; stPRdata[20] = 64'hBAD;
        stPRv[21] = 1'b1; stPRdata[21] = 64'hBAD;
        // withheld response to FAST_INTR_CTRL
        txnTmo(23, 0, 32'h1A10_9804, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 1, 37, 64'h5555, 40);
        // reset while in RESP, then a fresh contended round
        txnRst(43, 1, 32'h1A10_2100, 1'b0, 8'hFF, 64'h0, 0, 47);
        txnOk(49, 49, 0, 32'h1A10_4010, 1'b0, 8'hFF, 64'h0, 0, 1, 64'h77, 1'b1);
        txnOk(49, 52, 1, 32'h1A10_2104, 1'b1, 8'h0F, 64'hCAFE, 2, 1, 64'h0, 1'b0);
        stPRv[58] = 1'b1; stPRdata[58] = 64'h99;

        drive(0);
        for (int c = 0; c < NumCyc; c++) begin
            @(posedge clk);
            #1;
            drive(c);
        end
    end

    initial begin
        for (int c = 0; c < NumCyc; c++) begin
            @(negedge clk);
            chk("gnt_o", c, 64'(gnt), 64'(expGnt[c]));
            chk("rvalid_o", c, 64'(rvalid), 64'(expRv[c]));
            chk("err_o", c, 64'(err), 64'(expErr[c]));
            chk("rdata_o", c, rdata, expRdata[c]);
            chk("periph_req_o", c, 64'(pReq), 64'(expPReq[c]));
            chk("periph_we_o", c, 64'(pWe), 64'(expPWe[c]));
            chk("periph_addr_o", c, 64'(pAddr), 64'(expPAddr[c]));
            chk("periph_be_o", c, 64'(pBe), 64'(expPBe[c]));
            chk("periph_wdata_o", c, pWdata, expPWdata[c]);
            chk("busy_o", c, 64'(busy), 64'(expBusy[c]));
            chk("timeout_o", c, 64'(tmo), 64'(expTmo[c]));
            case (c)
                1:  chk("lit_reset_busy", c, 64'(busy), 64'h0);
                4:  chk("lit_req_not_yet", c, 64'(pReq), 64'h0);
                5: begin
                    chk("lit_first_req", c, 64'(pReq), 64'h1);
                    chk("lit_first_gnt", c, 64'(gnt), 64'h1);
                    chk("lit_first_addr", c, 64'(pAddr), 64'h1A10_2108);
                end
                8:  chk("lit_second_gnt", c, 64'(gnt), 64'h2);
                14: chk("lit_latched_addr", c, 64'(pAddr), 64'h1A10_4000);
                16: chk("lit_no_early_rv", c, 64'(rvalid), 64'h0);
                17: begin
                    chk("lit_rv_same_cycle", c, 64'(rvalid), 64'h1);
                    chk("lit_rdata_beef", c, rdata, 64'hDEAD_BEEF);
                end
                20: begin
                    chk("lit_decerr_gnt", c, 64'(gnt), 64'h2);
                    chk("lit_decerr_noreq", c, 64'(pReq), 64'h0);
                end
                21: begin
                    chk("lit_decerr_err", c, 64'(err), 64'h2);
                    chk("lit_decerr_rdata", c, rdata, 64'h0);
                end
                33: chk("lit_tmo_not_yet", c, 64'(rvalid), 64'h0);
                34: chk("lit_tmo_err", c, 64'(err), 64'h1);
                35: chk("lit_tmo_flag", c, 64'(tmo), 64'h1);
                37: begin
                    chk("lit_late_dropped", c, 64'(rvalid), 64'h0);
                    chk("lit_abort_busy", c, 64'(busy), 64'h1);
                end
                38: chk("lit_abort_done", c, 64'(busy), 64'h0);
                41: chk("lit_tmo_cleared", c, 64'(tmo), 64'h0);
                47: chk("lit_rst_busy", c, 64'(busy), 64'h0);
                50: chk("lit_post_rst_gnt", c, 64'(gnt), 64'h1);
                51: chk("lit_err_forward", c, 64'(err), 64'h1);
                default: ;
            endcase
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ni_periph_arbiter.md
NI_PERIPH_ARBITER -- requirements
Module: ni_periph_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of OBI-style requesters (2..4).
REQ-002 SHALL have parameter AddrWidth, default core_v_mcu_pkg::AxiAddrWidth, request address width.
REQ-003 SHALL have parameter DataWidth, default 64, data width; byte enables are DataWidth/8 bits.
REQ-004 SHALL have parameter TimeoutCycles, default 255, maximum wait for periph_rvalid_i (1..65535).
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports req_i / we_i, input, NumReq, per-requester request and write flag.
REQ-008 SHALL have ports addr_i / be_i / wdata_i, input, NumReq x (AddrWidth / DataWidth/8 / DataWidth), per-requester payload.
REQ-009 SHALL have ports gnt_o / rvalid_o / err_o, output, NumReq, per-requester grant, response valid and error.
REQ-010 SHALL have port rdata_o, output, DataWidth, read data shared by all requesters, qualified by rvalid_o.
REQ-011 SHALL have ports periph_req_o, periph_we_o, periph_addr_o, periph_be_o, periph_wdata_o, output, downstream request.
REQ-012 SHALL have ports periph_gnt_i, periph_rvalid_i, periph_err_i (1 bit each) and periph_rdata_i (DataWidth), input, downstream response.
REQ-013 SHALL have port timeout_o, output, 1, sticky timeout flag; clr_timeout_i, input, 1, clears it.
REQ-014 SHALL have port busy_o, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, RESP, DECERR, ABORT.
REQ-016 IDLE: if any req_i is high, SHALL select an owner round-robin, starting from the index after the last owner, and latch its payload; next state is REQ if the address decodes, else DECERR.
REQ-017 Decode: address SHALL hit if it falls in [base, base+size) of SOC_CTRL, FAST_INTR_CTRL or UART, using the core_v_mcu_pkg start addresses and sizes.
REQ-018 REQ: SHALL drive periph_req_o=1 with the latched payload; gnt_o[owner]=periph_gnt_i (combinational); on periph_gnt_i go to RESP.
REQ-019 RESP: on periph_rvalid_i SHALL pulse rvalid_o[owner] for 1 cycle with rdata_o=periph_rdata_i and err_o[owner]=periph_err_i, then go to IDLE.
REQ-020 DECERR: SHALL pulse gnt_o[owner] for 1 cycle, then pulse rvalid_o[owner] and err_o[owner] with rdata_o=0 the next cycle, then go to IDLE; periph_req_o SHALL stay 0.
REQ-021 Timeout: a counter SHALL reset on entry to RESP and increment each RESP cycle; when it reaches TimeoutCycles without periph_rvalid_i, the block SHALL pulse rvalid_o/err_o[owner], set timeout_o and go to ABORT.
REQ-022 ABORT: SHALL discard the late periph_rvalid_i and then go to IDLE; no grants are issued while in ABORT.
REQ-023 There SHALL be at most one outstanding downstream transaction.
REQ-024 Latency: minimum request-to-gnt is 1 cycle (IDLE->REQ); the response is forwarded in the same cycle as periph_rvalid_i.
REQ-025 Requesters SHALL hold req_i and payload stable until gnt_o; the block SHALL ignore payload changes after latching.
REQ-026 If clr_timeout_i and a new timeout occur in the same cycle, set SHALL win.
REQ-027 periph_rvalid_i arriving in IDLE, REQ or DECERR SHALL be ignored.

Reset
REQ-028 On rst_i the FSM SHALL go to IDLE, with the RR pointer = NumReq-1 (requester 0 wins first), the counter = 0 and timeout_o = 0.
REQ-029 During and after reset all outputs SHALL be 0, including outputs for any transaction in flight when reset was applied; no response is owed to it.

Structure
REQ-030 The region base/size list and the FSM state enum SHALL live in a shared package, ni_periph_arbiter_pkg; the region base/size list is sourced from core_v_mcu_pkg.
REQ-031 Round-robin selection SHALL be one sub-module, rr_select (request vector and last-owner in; one-hot grant and index out).

Verification
REQ-032 Simultaneous req_i=2'b11 after reset, targeting a UART read -> requester 0 is served first, then requester 1; periph_req_o rises 1 cycle after the requests.
REQ-033 Read of SOC_CTRL base, periph_gnt_i delayed 3 cycles, periph_rvalid_i 2 cycles later with rdata 64'hDEAD_BEEF -> rvalid_o[0]=1 and rdata_o=64'hDEAD_BEEF in that same cycle.
REQ-034 Access to address 64'h0 (unmapped) -> gnt_o 1 cycle after the request, rvalid_o+err_o the next cycle, periph_req_o never asserted.
REQ-035 TimeoutCycles=8 with periph_rvalid_i withheld -> err after 8 RESP cycles and timeout_o=1; a late rvalid is not forwarded; clr_timeout_i clears timeout_o.
REQ-036 rst_i asserted while in RESP -> next cycle busy_o=0 and all outputs 0; the next request is accepted normally.
